// File: rtl/cellnet_sink_checker.sv
// Sink for a cellnet token source: 4-phase req/ack receiver that checks the address/data walk.
// Optional randomised ack back-pressure is built when CELLNET_SNK_BACKPRESSURE_EN is defined.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module cellnet_sink_checker #(
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 1,
    parameter int ASZ      = `ADDRESS_SIZE,
    parameter int DSZ      = `DATA_SIZE,
    parameter int CNT_SZ   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ASZ-1:0]    i_addr,
    input  logic [DSZ-1:0]    i_dat,
    input  logic              i_req,
    output logic              o_ack,
    input  logic              i_clr,
    output logic              o_synced,
    output logic              o_err,
    output logic [CNT_SZ-1:0] o_err_cnt,
    output logic [CNT_SZ-1:0] o_xfer_cnt,
    output logic [ASZ-1:0]    o_last_addr,
    output logic [DSZ-1:0]    o_last_dat
);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_ACK   = 2'd1;
`ifdef CELLNET_SNK_BACKPRESSURE_EN
    localparam logic [1:0] S_STALL = 2'd2;
`endif

    localparam logic [ASZ-1:0] L_MIN = ASZ'(MIN_ADDR);
    localparam logic [ASZ-1:0] L_MAX = ASZ'(MAX_ADDR);

    logic [1:0]        r_state;
    logic              r_ack;
    logic              r_synced;
    logic              r_err;
    logic [CNT_SZ-1:0] r_err_cnt;
    logic [CNT_SZ-1:0] r_xfer_cnt;
    logic [ASZ-1:0]    r_last_addr;
    logic [DSZ-1:0]    r_last_dat;
    logic [ASZ-1:0]    r_exp_addr;
    logic [DSZ-1:0]    r_exp_dat;

    logic              w_capture;
    logic              w_ref_valid;
    logic              w_in_range;
    logic              w_mismatch;
    logic              w_err_sat;
    logic [ASZ-1:0]    w_next_addr;
    logic [DSZ-1:0]    w_next_dat;

    // A token is taken exactly once: on the edge where req is first seen high in S_WAIT.
    assign w_capture   = (r_state == S_WAIT) && i_req;
    // A clear on the capture edge makes this token the first one after clear.
    assign w_ref_valid = r_synced && !i_clr;
    assign w_in_range  = (i_addr >= L_MIN) && (i_addr <= L_MAX);
    assign w_mismatch  = w_ref_valid &&
                         (!w_in_range || (i_addr != r_exp_addr) || (i_dat != r_exp_dat));
    assign w_err_sat   = &r_err_cnt;

    always_comb begin
        w_next_addr = i_addr + ASZ'(1);
        w_next_dat  = i_dat;
        if (i_addr == L_MAX) begin
            w_next_addr = L_MIN;
            w_next_dat  = i_dat + DSZ'(1);
        end
    end

`ifdef CELLNET_SNK_BACKPRESSURE_EN
    logic [7:0] r_lfsr;
    logic [2:0] r_stall_cnt;
    logic       w_lfsr_fb;

    // Fibonacci form of x^8+x^6+x^5+x^4+1.
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_WAIT;
            r_ack       <= 1'b0;
            r_stall_cnt <= 3'd0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (i_req) begin
                        if (r_lfsr[2:0] == 3'd0) begin
                            r_ack   <= 1'b1;
                            r_state <= S_ACK;
                        end else begin
                            r_stall_cnt <= r_lfsr[2:0];
                            r_state     <= S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    // Clear is deliberately ignored here: the pending ack is never cancelled.
                    if (r_stall_cnt == 3'd1) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - 3'd1;
                    end
                end
                S_ACK: begin
                    if (!i_req) begin
                        r_ack   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_WAIT;
                end
            endcase
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_WAIT;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (i_req) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!i_req) begin
                        r_ack   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_WAIT;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_synced    <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_xfer_cnt  <= '0;
            r_last_addr <= '0;
            r_last_dat  <= '0;
            r_exp_addr  <= L_MIN;
            r_exp_dat   <= '0;
        end else if (w_capture) begin
            r_last_addr <= i_addr;
            r_last_dat  <= i_dat;
            // The reference always follows the received token, so one glitch costs one error.
            r_exp_addr  <= w_next_addr;
            r_exp_dat   <= w_next_dat;
            r_synced    <= 1'b1;
            if (i_clr) begin
                r_xfer_cnt <= CNT_SZ'(1);
                r_err_cnt  <= '0;
                r_err      <= 1'b0;
            end else begin
                r_xfer_cnt <= r_xfer_cnt + CNT_SZ'(1);
                if (w_mismatch) begin
                    r_err <= 1'b1;
                    if (!w_err_sat) begin
                        r_err_cnt <= r_err_cnt + CNT_SZ'(1);
                    end
                end
            end
        end else if (i_clr) begin
            r_xfer_cnt <= '0;
            r_err_cnt  <= '0;
            r_err      <= 1'b0;
            r_synced   <= 1'b0;
        end
    end

    assign o_ack       = r_ack;
    assign o_synced    = r_synced;
    assign o_err       = r_err;
    assign o_err_cnt   = r_err_cnt;
    assign o_xfer_cnt  = r_xfer_cnt;
    assign o_last_addr = r_last_addr;
    assign o_last_dat  = r_last_dat;

endmodule

// File: tb/tb_cellnet_sink_checker.sv
// Bench for cellnet_sink_checker: scenario tasks drive 4-phase tokens, an ack-edge monitor drains the expected queue.
`timescale 1ns/1ps

module tb_cellnet_sink_checker;

    localparam int MIN_A = 1;
    localparam int MAX_A = 3;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int CW    = 16;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          req;
    logic          clr;
    logic          o_ack;
    logic          o_synced;
    logic          o_err;
    logic [CW-1:0] o_err_cnt;
    logic [CW-1:0] o_xfer_cnt;
    logic [AW-1:0] o_last_addr;
    logic [DW-1:0] o_last_dat;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [CW-1:0] xfer;
        logic [CW-1:0] errc;
        logic          err;
        logic          syn;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_exp;
    exp_t sb_got;
    logic prev_ack = 1'b0;

    // reference model of the expected walk
    logic          m_synced;
    logic [AW-1:0] m_ea;
    logic [DW-1:0] m_ed;
    logic [CW-1:0] m_xfer;
    logic [CW-1:0] m_errc;
    logic          m_err;

    cellnet_sink_checker #(
        .MIN_ADDR(MIN_A), .MAX_ADDR(MAX_A), .ASZ(AW), .DSZ(DW), .CNT_SZ(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_dat(dat), .i_req(req),
        .o_ack(o_ack), .i_clr(clr), .o_synced(o_synced), .o_err(o_err),
        .o_err_cnt(o_err_cnt), .o_xfer_cnt(o_xfer_cnt),
        .o_last_addr(o_last_addr), .o_last_dat(o_last_dat)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic model_reset();
        m_synced = 1'b0;
        m_ea     = AW'(MIN_A);
        m_ed     = '0;
        m_xfer   = '0;
        m_errc   = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_clear();
        m_synced = 1'b0;
        m_xfer   = '0;
        m_errc   = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        logic bad;
        exp_t e;
        bad = 1'b0;
        if (m_synced && !c) begin
            if (a < AW'(MIN_A) || a > AW'(MAX_A) || a != m_ea || d != m_ed) bad = 1'b1;
        end
        if (c) begin
            m_xfer = 16'd1;
            m_errc = '0;
            m_err  = 1'b0;
        end else begin
            m_xfer = m_xfer + 16'd1;
            if (bad) begin
                m_err = 1'b1;
                if (m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
            end
        end
        m_synced = 1'b1;
        if (a == AW'(MAX_A)) begin
            m_ea = AW'(MIN_A);
            m_ed = d + 8'd1;
        end else begin
            m_ea = a + 4'd1;
            m_ed = d;
        end
        e.a = a; e.d = d; e.xfer = m_xfer; e.errc = m_errc; e.err = m_err; e.syn = m_synced;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every rising ack must present the next expected token and counters.
    always @(negedge clk) begin
        if (rst_n && o_ack && !prev_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: ack rose with no expected token (last addr=%0d dat=%0d)",
                         o_last_addr, o_last_dat);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_got = {o_last_addr, o_last_dat, o_xfer_cnt, o_err_cnt, o_err, o_synced};
                if (sb_got !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_token: got addr=%0d dat=%0d xfer=%0d errc=%0d err=%0d syn=%0d, expected addr=%0d dat=%0d xfer=%0d errc=%0d err=%0d syn=%0d",
                             sb_got.a, sb_got.d, sb_got.xfer, sb_got.errc, sb_got.err, sb_got.syn,
                             sb_exp.a, sb_exp.d, sb_exp.xfer, sb_exp.errc, sb_exp.err, sb_exp.syn);
                end
            end
        end
        prev_ack = o_ack;
    end

    // Full 4-phase transfer; c raises i_clr on the capture edge only.
    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        int n;
        @(negedge clk);
        model_push(a, d, c);
        addr = a; dat = d; req = 1'b1; clr = c;
        n = 0;
        while (!o_ack && n < 20) begin
            @(negedge clk);
            clr = 1'b0;
            n++;
        end
        checks++;
        if (!o_ack) begin
            errors++;
            $display("FAIL ack_timeout: ack=%0d after %0d cycles, required 1", o_ack, n);
        end
`ifndef CELLNET_SNK_BACKPRESSURE_EN
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL ack_latency: ack after %0d cycles, required 1", n);
        end
`endif
        req = 1'b0;
        n = 0;
        while (o_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_ack) begin
            errors++;
            $display("FAIL ack_release: ack=%0d after req low, required 0", o_ack);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        checks++;
        if ({o_synced, o_err, o_xfer_cnt, o_err_cnt} !== {1'b0, 1'b0, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL clear: synced=%0d err=%0d xfer=%0d errc=%0d, required all 0",
                     o_synced, o_err, o_xfer_cnt, o_err_cnt);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (o_ack !== 1'b0 || o_synced !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ack=%0d synced=%0d err=%0d, required 0", o_ack, o_synced, o_err);
        end
        checks++;
        if (o_xfer_cnt !== 16'd0 || o_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: xfer=%0d errc=%0d, required 0", o_xfer_cnt, o_err_cnt);
        end
        checks++;
        if (o_last_addr !== 4'd0 || o_last_dat !== 8'd0) begin
            errors++;
            $display("FAIL reset_last: addr=%0d dat=%0d, required 0", o_last_addr, o_last_dat);
        end
    endtask

    task automatic test_in_order();
        send(4'd2, 8'd0, 1'b0);
        send(4'd3, 8'd0, 1'b0);
        send(4'd1, 8'd1, 1'b0);
        send(4'd2, 8'd1, 1'b0);
        send(4'd3, 8'd1, 1'b0);
        send(4'd1, 8'd2, 1'b0);
        checks++;
        if (o_xfer_cnt !== 16'd6 || o_err_cnt !== 16'd0 || o_err !== 1'b0 || o_synced !== 1'b1) begin
            errors++;
            $display("FAIL in_order: xfer=%0d errc=%0d err=%0d synced=%0d, required 6/0/0/1",
                     o_xfer_cnt, o_err_cnt, o_err, o_synced);
        end
        checks++;
        if (o_last_addr !== 4'd1 || o_last_dat !== 8'd2) begin
            errors++;
            $display("FAIL in_order_last: addr=%0d dat=%0d, required 1/2", o_last_addr, o_last_dat);
        end
    endtask

    task automatic test_glitch();
        pulse_clear();
        send(4'd3, 8'd0, 1'b0);
        send(4'd2, 8'd0, 1'b0);
        send(4'd3, 8'd0, 1'b0);
        checks++;
        if (o_err_cnt !== 16'd1 || o_err !== 1'b1 || o_xfer_cnt !== 16'd3) begin
            errors++;
            $display("FAIL glitch: errc=%0d err=%0d xfer=%0d, required 1/1/3", o_err_cnt, o_err, o_xfer_cnt);
        end
    endtask

    task automatic test_out_of_range();
        pulse_clear();
        send(4'd3, 8'd4, 1'b0);
        send(4'd5, 8'd4, 1'b0);
        send(4'd1, 8'd5, 1'b0);
        checks++;
        if (o_err_cnt !== 16'd2 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range: errc=%0d err=%0d, required 2/1", o_err_cnt, o_err);
        end
    endtask

    task automatic test_data_wrap();
        pulse_clear();
        send(4'd2, 8'd255, 1'b0);
        send(4'd3, 8'd255, 1'b0);
        send(4'd1, 8'd0, 1'b0);
        checks++;
        if (o_err_cnt !== 16'd0 || o_err !== 1'b0 || o_last_dat !== 8'd0) begin
            errors++;
            $display("FAIL data_wrap: errc=%0d err=%0d last_dat=%0d, required 0/0/0",
                     o_err_cnt, o_err, o_last_dat);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        model_push(4'd2, 8'd9, 1'b0);
        addr = 4'd2; dat = 8'd9; req = 1'b1;
        n = 0;
        while (!o_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (o_ack !== 1'b0 || o_xfer_cnt !== 16'd0 || o_err_cnt !== 16'd0 || o_synced !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ack=%0d xfer=%0d errc=%0d synced=%0d, required all 0",
                     o_ack, o_xfer_cnt, o_err_cnt, o_synced);
        end
        addr = 4'd1; dat = 8'd5;
        @(negedge clk);
        model_push(4'd1, 8'd5, 1'b0);
        rst_n = 1'b1;
        n = 0;
        while (!o_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_ack !== 1'b1 || o_synced !== 1'b1 || o_xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_release: ack=%0d synced=%0d xfer=%0d, required 1/1/1",
                     o_ack, o_synced, o_xfer_cnt);
        end
        req = 1'b0;
        n = 0;
        while (o_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_clear_on_capture();
        pulse_clear();
        send(4'd1, 8'd0, 1'b0);
        send(4'd2, 8'd0, 1'b0);
        send(4'd3, 8'd0, 1'b0);
        send(4'd3, 8'd0, 1'b0);
        send(4'd1, 8'd1, 1'b0);
        send(4'd2, 8'd1, 1'b0);
        send(4'd2, 8'd1, 1'b0);
        send(4'd3, 8'd1, 1'b0);
        send(4'd1, 8'd3, 1'b0);
        send(4'd2, 8'd3, 1'b0);
        checks++;
        if (o_xfer_cnt !== 16'd10 || o_err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL pre_clear: xfer=%0d errc=%0d, required 10/3", o_xfer_cnt, o_err_cnt);
        end
        send(4'd2, 8'd7, 1'b1);
        checks++;
        if (o_xfer_cnt !== 16'd1 || o_err_cnt !== 16'd0 || o_err !== 1'b0 || o_synced !== 1'b1) begin
            errors++;
            $display("FAIL clear_capture: xfer=%0d errc=%0d err=%0d synced=%0d, required 1/0/0/1",
                     o_xfer_cnt, o_err_cnt, o_err, o_synced);
        end
        send(4'd3, 8'd7, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = AW'($urandom_range(0, 15));
                d = DW'($urandom_range(0, 255));
            end else begin
                a = m_ea;
                d = m_ed;
            end
            send(a, d, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        clr   = 1'b0;
        addr  = '0;
        dat   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_in_order();
        test_glitch();
        test_out_of_range();
        test_data_wrap();
        test_reset_mid();
        test_clear_on_capture();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected tokens never acknowledged, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cellnet_sink_checker.md
Name: cellnet_sink_checker

Overview:
- Downstream consumer for a cellnet token source.
- Accepts address/data tokens over a 4-phase req/ack handshake and checks each against the expected sequence: address walks MIN_ADDR..MAX_ADDR, data increments when the address wraps.
- Counts transfers and errors and holds the last token for debug/LED output in FPGA source/sink tests.

Parameters:
- MIN_ADDR, 1, lowest legal address; expected address after a MAX_ADDR token
- MAX_ADDR, 1, highest legal address
- ASZ, `ADDRESS_SIZE, address width
- DSZ, `DATA_SIZE, data width
- CNT_SZ, 16, width of transfer and error counters

Ports:
- i_clk  in  1  main clock (25 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_addr  in  ASZ  token address from source
- i_dat  in  DSZ  token data from source
- i_req  in  1  source request (4-phase)
- o_ack  out  1  sink acknowledge (4-phase)
- i_clr  in  1  synchronous clear of counters, error flag and sync state
- o_synced  out  1  first token received since reset/clear
- o_err  out  1  sticky: at least one sequence error seen
- o_err_cnt  out  CNT_SZ  error count, saturating
- o_xfer_cnt  out  CNT_SZ  accepted-token count, wrapping
- o_last_addr  out  ASZ  address of last accepted token
- o_last_dat  out  DSZ  data of last accepted token

Behaviour:
- Reset (async, i_rst_n=0): state S_WAIT.
  - o_ack, o_synced, o_err = 0.
  - Both counters = 0; o_last_addr/o_last_dat = 0.
  - Internal expected address = MIN_ADDR; expected data = 0.
- Same clock domain as the source; inputs are sampled directly, with no synchroniser.
- S_WAIT (o_ack=0), i_req=1 seen on an edge:
  - Capture i_addr/i_dat into o_last_*.
  - Increment o_xfer_cnt.
  - Run the check.
  - Set o_ack=1 on the same edge (visible the cycle after req is sampled high).
  - Go to S_ACK.
- S_ACK (o_ack=1), i_req=0 seen: clear o_ack; go to S_WAIT. While i_req stays 1, hold o_ack=1 indefinitely.
- i_req=0 in S_WAIT and i_req=1 in S_ACK: no action.
- Check rules (all on the capture edge):
  - Not synced: no error. Set o_synced=1 and adopt the token as the reference.
  - Synced, address outside [MIN_ADDR, MAX_ADDR]: error.
  - Synced, token != expected: error.
- Error action: o_err=1 (sticky); o_err_cnt+1, saturating at all-ones. Then resync the reference to the received token, so a single glitch yields exactly one error.
- Next expected value, computed from the accepted token:
  - If addr==MAX_ADDR: addr=MIN_ADDR, dat=dat+1 modulo 2^DSZ (wraps, not an error).
  - Otherwise: addr+1, same dat.
- MIN_ADDR==MAX_ADDR: address is constant and data increments on every token.
- i_clr=1 (synchronous):
  - Zeroes the counters, o_err and o_synced.
  - Does not touch o_ack or the handshake state.
  - If i_clr coincides with a capture: the token is still acknowledged and latched into o_last_*, and it becomes the first token after clear. Result: o_synced=1, o_xfer_cnt=1, no error.
- o_xfer_cnt wraps to 0 after all-ones.
- Reset asserted mid-handshake: o_ack drops immediately (async). After release the block waits in S_WAIT; a still-high i_req is accepted as a new token.

Optional Feature:
- Macro: CELLNET_SNK_BACKPRESSURE_EN.
- Defined:
  - Adds state S_STALL and a free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5).
  - On req seen in S_WAIT, the token is captured and checked immediately, but o_ack rises only after a delay of N = LFSR[2:0] cycles (0..7) spent in S_STALL.
  - N=0 behaves exactly as the undefined case.
  - i_clr during S_STALL does not cancel the pending ack.
- Undefined: no LFSR and no S_STALL; ack timing is exactly as described in Behaviour.

Test Plan:
- Reset, then MIN=1, MAX=3, DSZ=8; drive tokens (2,0),(3,0),(1,1),(2,1),(3,1),(1,2) with a correct 4-phase handshake -> o_synced=1, o_xfer_cnt=6, o_err=0, o_err_cnt=0, o_last=(1,2). Each ack rises 1 cycle after req (macro undefined).
- After synced at (3,0), send (2,0) then (3,0) -> o_err_cnt=1 (first mismatch only, reference resynced), o_err=1, o_xfer_cnt increments by 2.
- Send out-of-range address 5 with MAX=3 -> error counted; the next correct successor of (5,d) is not possible, so (1,d) is flagged per rules; the bench checks o_err_cnt=2 exactly.
- DSZ=8 data wrap: (3,255) then (1,0) -> no error; o_last_dat=0.
- Assert i_rst_n=0 while o_ack=1 -> o_ack=0 the same cycle and counters=0. Release with i_req=1 -> token accepted, o_synced=1, o_xfer_cnt=1.
- Pulse i_clr on a capture edge of (2,7) after 10 tokens with 3 errors -> o_xfer_cnt=1, o_err_cnt=0, o_err=0, o_synced=1, o_ack=1 next cycle.
